// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch state encoding, NOP encoding and default widths.
// The ID/EX register and the hazard unit import the same values.
package pipe_pkg;

    localparam int          PC_W_DEF      = 16;
    localparam int          INSTR_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/fetch_pipe_ctrl_if_id_reg.sv
// IF/ID pipeline register with hold and flush-to-NOP controls.
// Priority inside the register is reset, then flush, then load; otherwise it holds.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic [PC_W-1:0]    q_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic               q_valid
);

    logic [PC_W-1:0]    pc_d,    pc_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               valid_d, valid_q;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = d_pc;
            instr_d = d_instr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign q_pc    = pc_q;
    assign q_instr = instr_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side responder to the hazard unit: PC, IF/ID register, branch flush and halt.
// Optional PERF_CNT_EN adds saturating stall-cycle and flush counters.
module fetch_pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PC_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               if_id_write,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               halt_dec,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               id_ex_bubble,
    output logic               halted
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]        stall_cycles,
    output logic [15:0]        flush_count
`endif
);

    pipe_state_e     state_d, state_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic            halted_d, halted_q;
    logic            ifid_load, ifid_flush;
    logic            hold_req;
    logic [PC_W-1:0] pc_inc;

    assign hold_req = !pc_write || !if_id_write;
    assign pc_inc   = pc_q + PC_W'(1);

    // Priority: branch flush > decoded halt > hold request > normal fetch; HALT ignores all.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        halted_d     = halted_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst || state_q == HALT) begin
            id_ex_bubble = 1'b0;
        end else if (br_taken) begin
            pc_d         = br_target;
            ifid_flush   = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
        end else if (halt_dec) begin
            ifid_flush   = 1'b1;
            halted_d     = 1'b1;
            state_d      = HALT;
        end else begin
            if (pc_write) begin
                pc_d = pc_inc;
            end
            ifid_load    = if_id_write;
            id_ex_bubble = stall;
            state_d      = hold_req ? STALL : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .d_pc    (pc_inc),
        .d_instr (imem_instr),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

    assign pc     = pc_q;
    assign halted = halted_q;

`ifdef PERF_CNT_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    // Counters saturate at all-ones and freeze once halted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != HALT) begin
            if (hold_req && !br_taken && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (br_taken && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule
